mp_regfile: RTL and testbench
=============================

MP_REGFILE -- requirements
Module: mp_regfile

Interface
REQ-001 DATA_W, 32, register width in bits; SHALL be a multiple of 8, else elaboration error.
REQ-002 ADDR_W, 5, address width; depth SHALL be 2**ADDR_W.
REQ-003 BYPASS, 1, 1 = same-cycle write-to-read forwarding; 0 = reads return stored value only.
REQ-004 clk  input  1  system clock; all state SHALL update on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 we0  input  1  write port 0 enable.
REQ-007 wa0  input  ADDR_W  write port 0 address.
REQ-008 wd0  input  DATA_W  write port 0 data.
REQ-009 wbe0  input  DATA_W/8  write port 0 byte enables.
REQ-010 we1  input  1  write port 1 enable (higher priority).
REQ-011 wa1  input  ADDR_W  write port 1 address.
REQ-012 wd1  input  DATA_W  write port 1 data.
REQ-013 wbe1  input  DATA_W/8  write port 1 byte enables.
REQ-014 ra1, ra2  input  ADDR_W each  read port addresses.
REQ-015 rd1, rd2  output  DATA_W each  read port data.
REQ-016 iss_v  input  1  issue valid: marks iss_a as pending producer.
REQ-017 iss_a  input  ADDR_W  destination register of issued instruction.
REQ-018 busy1, busy2  output  1 each  pending status of ra1, ra2.
REQ-019 nbusy  output  ADDR_W+1  count of pending registers.
REQ-020 dbg_sel  input  ADDR_W  debug read address.
REQ-021 dbg_data  output  DATA_W  debug read data.

Function
REQ-022 Register 0 SHALL read 0, ignore writes, never be busy.
REQ-023 At rising edge, for each port with weN=1 and waN!=0, byte k SHALL be written from wdN where wbeN[k]=1; other bytes unchanged.
REQ-024 Both ports writing the same address: per byte, port 1 SHALL win where wbe1[k]=1; port 0 bytes not covered by wbe1 SHALL still be written.
REQ-025 rd1/rd2 SHALL be combinational, zero latency; ra=0 returns 0.
REQ-026 BYPASS=1: when ra matches an active write address, rd SHALL return the byte-merged next value per REQ-023/024; BYPASS=0: stored value.
REQ-027 iss_v=1 with iss_a!=0 SHALL set busy[iss_a] at the edge.
REQ-028 Any active write (weN=1, any wbeN) to register r SHALL clear busy[r] at the edge.
REQ-029 Issue and write to the same register in one cycle: set SHALL win (busy stays/becomes 1).
REQ-030 busyN SHALL reflect registered busy[raN]; BYPASS=1 SHALL mask busyN to 0 when a write to raN is active this cycle.
REQ-031 nbusy SHALL equal population count of busy bits, updated registered at the same edge as busy; range 0..2**ADDR_W-1.
REQ-032 dbg_data SHALL return stored value, no bypass; dbg_sel=0 returns 0.

Reset
REQ-033 rst=0 SHALL immediately clear all registers, all busy bits and nbusy, independent of clk.
REQ-034 While rst=0, writes and issues SHALL be ignored; rd1, rd2, dbg_data read 0, busy1, busy2 read 0.
REQ-035 Reset asserted mid-operation SHALL discard all pending state; first edge after release behaves as a normal cycle.

Structure
REQ-036 Package mp_rf_pkg SHALL hold default DATA_W/ADDR_W constants and the byte-merge function shared by write and bypass paths.
REQ-037 Sub-module rf_scoreboard SHALL hold busy bits, set/clear priority and nbusy counter.

Verification
REQ-038 Write r5=0x12345678 wbe=4'hF, next cycle read ra1=5 -> rd1=0x12345678; write r0=0xFFFFFFFF -> rd 0.
REQ-039 Same cycle we0 r3=0xAAAAAAAA wbe0=F, we1 r3=0x55555555 wbe1=4'h3 -> r3=0xAAAA5555; BYPASS=1 rd1(ra1=3) same cycle=0xAAAA5555.
REQ-040 iss r7, then write r7 -> busy1(ra1=7) 1 for one cycle, then 0, nbusy 1->0; issue+write r7 same cycle -> busy stays 1.
REQ-041 Issue r1..r31 consecutively -> nbusy reaches 31; issue r0 -> nbusy unchanged.
REQ-042 Fill r1..r4, busy r2, pull rst low between edges -> all reads 0, nbusy 0 immediately.

Source files
------------

// File: rtl/mp_rf_pkg.sv
// Shared constants and the byte-merge helper for the multi-port register file.
// The write path and the forwarding path both call byte_merge, so they cannot disagree.
package mp_rf_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;

   // Widest register the merge helper supports; callers zero-extend into it
   localparam int MERGE_W = 1024;
   localparam int MERGE_B = MERGE_W / 8;

   function automatic logic [MERGE_W-1:0] byte_merge(
      input logic [MERGE_W-1:0] old_v,
      input logic [MERGE_W-1:0] new_v,
      input logic [MERGE_B-1:0] be
   );
      logic [MERGE_W-1:0] res;
      res = {MERGE_W{1'b0}};
      for (int k = 0; k < MERGE_B; k++) begin
         res[k*8 +: 8] = be[k] ? new_v[k*8 +: 8] : old_v[k*8 +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/mp_regfile_if.sv
// Bus bundle for mp_regfile: two write ports, two read ports, issue/busy and debug read.
interface mp_regfile_if
   import mp_rf_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) ();

   logic                  we0;
   logic [ADDR_W-1:0]     wa0;
   logic [DATA_W-1:0]     wd0;
   logic [DATA_W/8-1:0]   wbe0;
   logic                  we1;
   logic [ADDR_W-1:0]     wa1;
   logic [DATA_W-1:0]     wd1;
   logic [DATA_W/8-1:0]   wbe1;
   logic [ADDR_W-1:0]     ra1;
   logic [ADDR_W-1:0]     ra2;
   logic [DATA_W-1:0]     rd1;
   logic [DATA_W-1:0]     rd2;
   logic                  iss_v;
   logic [ADDR_W-1:0]     iss_a;
   logic                  busy1;
   logic                  busy2;
   logic [ADDR_W:0]       nbusy;
   logic [ADDR_W-1:0]     dbg_sel;
   logic [DATA_W-1:0]     dbg_data;

   modport master (
      output we0, wa0, wd0, wbe0, we1, wa1, wd1, wbe1,
      output ra1, ra2, iss_v, iss_a, dbg_sel,
      input  rd1, rd2, busy1, busy2, nbusy, dbg_data
   );

   modport slave (
      input  we0, wa0, wd0, wbe0, we1, wa1, wd1, wbe1,
      input  ra1, ra2, iss_v, iss_a, dbg_sel,
      output rd1, rd2, busy1, busy2, nbusy, dbg_data
   );

endinterface

// File: rtl/rf_scoreboard.sv
// Per-register pending-producer bits with issue-over-write priority and a registered population count.
module rf_scoreboard
   import mp_rf_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   iss_v,
   input  logic [ADDR_W-1:0]      iss_a,
   input  logic                   clr0_v,
   input  logic [ADDR_W-1:0]      clr0_a,
   input  logic                   clr1_v,
   input  logic [ADDR_W-1:0]      clr1_a,
   output logic [2**ADDR_W-1:0]   busy,
   output logic [ADDR_W:0]        nbusy
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DEPTH-1:0] busy_r;
   logic [DEPTH-1:0] busy_nxt_s;
   logic [ADDR_W:0]  nbusy_r;
   logic [ADDR_W:0]  cnt_s;

   // Next busy vector and its population count; an issue beats a completing write
   always_comb begin
      busy_nxt_s    = busy_r;
      cnt_s         = {(ADDR_W+1){1'b0}};
      busy_nxt_s[0] = 1'b0;
      for (int r = 1; r < DEPTH; r++) begin
         busy_nxt_s[r] = (iss_v && (iss_a == ADDR_W'(r))) ? 1'b1 :
                         ((clr0_v && (clr0_a == ADDR_W'(r))) ||
                          (clr1_v && (clr1_a == ADDR_W'(r)))) ? 1'b0 : busy_r[r];
         cnt_s = cnt_s + (ADDR_W+1)'(busy_nxt_s[r]);
      end
   end

   // Busy bits and count update together so nbusy always matches busy
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_r  <= {DEPTH{1'b0}};
         nbusy_r <= {(ADDR_W+1){1'b0}};
      end else begin
         busy_r  <= busy_nxt_s;
         nbusy_r <= cnt_s;
      end
   end

   assign busy  = busy_r;
   assign nbusy = nbusy_r;

endmodule

// File: rtl/mp_regfile.sv
// Two-write/two-read register file with byte enables, optional write-to-read forwarding
// and a busy scoreboard for in-flight producers.
module mp_regfile
   import mp_rf_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter bit BYPASS = 1'b1
) (
   input logic         clk,
   input logic         rst,
   mp_regfile_if.slave bus
);

   localparam int                DEPTH  = 2 ** ADDR_W;
   localparam int                NB     = DATA_W / 8;
   localparam logic [ADDR_W-1:0] A_ZERO = {ADDR_W{1'b0}};
   localparam logic [DATA_W-1:0] D_ZERO = {DATA_W{1'b0}};

   if (((DATA_W % 8) != 0) || (DATA_W < 8) || (DATA_W > MERGE_W)) begin : g_bad_width
      $error("mp_regfile: DATA_W must be a nonzero multiple of 8 no wider than MERGE_W");
   end

   function automatic logic [DATA_W-1:0] merge_w(
      input logic [DATA_W-1:0] old_v,
      input logic [DATA_W-1:0] new_v,
      input logic [NB-1:0]     be
   );
      return DATA_W'(byte_merge(MERGE_W'(old_v), MERGE_W'(new_v), MERGE_B'(be)));
   endfunction

   logic [DATA_W-1:0] mem_r     [DEPTH];
   logic [DATA_W-1:0] mem_nxt_s [DEPTH];
   logic              wr0_act_s;
   logic              wr1_act_s;
   logic              hit1_s;
   logic              hit2_s;
   logic [DEPTH-1:0]  busy_s;
   logic [ADDR_W:0]   nbusy_s;

   assign wr0_act_s = bus.we0 && (bus.wa0 != A_ZERO);
   assign wr1_act_s = bus.we1 && (bus.wa1 != A_ZERO);
   assign hit1_s    = (wr0_act_s && (bus.wa0 == bus.ra1)) || (wr1_act_s && (bus.wa1 == bus.ra1));
   assign hit2_s    = (wr0_act_s && (bus.wa0 == bus.ra2)) || (wr1_act_s && (bus.wa1 == bus.ra2));

   // Next value of every register: port 0 bytes first, port 1 bytes layered on top
   always_comb begin
      logic [DATA_W-1:0] step_s;
      step_s       = D_ZERO;
      mem_nxt_s[0] = D_ZERO;
      for (int r = 1; r < DEPTH; r++) begin
         step_s = (wr0_act_s && (bus.wa0 == ADDR_W'(r))) ?
                  merge_w(mem_r[r], bus.wd0, bus.wbe0) : mem_r[r];
         mem_nxt_s[r] = (wr1_act_s && (bus.wa1 == ADDR_W'(r))) ?
                        merge_w(step_s, bus.wd1, bus.wbe1) : step_s;
      end
   end

   // Storage; entry 0 only ever loads the tied-off zero
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int r = 0; r < DEPTH; r++) begin
            mem_r[r] <= D_ZERO;
         end
      end else begin
         for (int r = 0; r < DEPTH; r++) begin
            mem_r[r] <= mem_nxt_s[r];
         end
      end
   end

   rf_scoreboard #(
      .ADDR_W (ADDR_W)
   ) u_sb (
      .clk    (clk),
      .rst    (rst),
      .iss_v  (bus.iss_v),
      .iss_a  (bus.iss_a),
      .clr0_v (wr0_act_s),
      .clr0_a (bus.wa0),
      .clr1_v (wr1_act_s),
      .clr1_a (bus.wa1),
      .busy   (busy_s),
      .nbusy  (nbusy_s)
   );

   // Read muxes; held at zero in reset so forwarded write data cannot leak out
   always_comb begin
      bus.rd1      = D_ZERO;
      bus.rd2      = D_ZERO;
      bus.dbg_data = D_ZERO;
      bus.busy1    = 1'b0;
      bus.busy2    = 1'b0;
      if (!rst) begin
         bus.rd1      = D_ZERO;
         bus.rd2      = D_ZERO;
         bus.dbg_data = D_ZERO;
         bus.busy1    = 1'b0;
         bus.busy2    = 1'b0;
      end else begin
         bus.rd1      = (BYPASS && hit1_s) ? mem_nxt_s[bus.ra1] : mem_r[bus.ra1];
         bus.rd2      = (BYPASS && hit2_s) ? mem_nxt_s[bus.ra2] : mem_r[bus.ra2];
         bus.dbg_data = mem_r[bus.dbg_sel];
         bus.busy1    = busy_s[bus.ra1] && !(BYPASS && hit1_s);
         bus.busy2    = busy_s[bus.ra2] && !(BYPASS && hit2_s);
      end
   end

   assign bus.nbusy = nbusy_s;

endmodule

// File: tb/tb_mp_regfile.sv
// Directed bench for mp_regfile: a forwarding instance and a stored-value-only instance
// share every stimulus vector.
module tb_mp_regfile;

   typedef struct {
      logic        we0;  logic [4:0] wa0; logic [31:0] wd0; logic [3:0] wbe0;
      logic        we1;  logic [4:0] wa1; logic [31:0] wd1; logic [3:0] wbe1;
      logic        iss_v; logic [4:0] iss_a;
      logic [4:0]  ra1;  logic [4:0] ra2; logic [4:0] dbg;
      logic [31:0] e_rd1; logic [31:0] e_rd2; logic [31:0] e_dbg; logic [31:0] e_rd1_nb;
      logic        e_b1; logic e_b2; logic [5:0] e_nb;
   } vec_t;

   logic clk;
   logic rst;
   int   n_err;
   int   n_checks;
   vec_t vt [18];
   vec_t h;

   mp_regfile_if #(.DATA_W(32), .ADDR_W(5)) bi ();
   mp_regfile_if #(.DATA_W(32), .ADDR_W(5)) bn ();

   mp_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) dut_byp (.clk(clk), .rst(rst), .bus(bi));
   mp_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) dut_nob (.clk(clk), .rst(rst), .bus(bn));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t idle_v();
      vec_t v;
      v = '{default: '0};
      return v;
   endfunction

   task automatic apply(input vec_t v);
      bi.we0 = v.we0; bi.wa0 = v.wa0; bi.wd0 = v.wd0; bi.wbe0 = v.wbe0;
      bi.we1 = v.we1; bi.wa1 = v.wa1; bi.wd1 = v.wd1; bi.wbe1 = v.wbe1;
      bi.iss_v = v.iss_v; bi.iss_a = v.iss_a;
      bi.ra1 = v.ra1; bi.ra2 = v.ra2; bi.dbg_sel = v.dbg;
      bn.we0 = v.we0; bn.wa0 = v.wa0; bn.wd0 = v.wd0; bn.wbe0 = v.wbe0;
      bn.we1 = v.we1; bn.wa1 = v.wa1; bn.wd1 = v.wd1; bn.wbe1 = v.wbe1;
      bn.iss_v = v.iss_v; bn.iss_a = v.iss_a;
      bn.ra1 = v.ra1; bn.ra2 = v.ra2; bn.dbg_sel = v.dbg;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   initial begin
      n_err    = 0;
      n_checks = 0;
      // we0 wa0 wd0 wbe0 | we1 wa1 wd1 wbe1 | iss_v iss_a | ra1 ra2 dbg | e_rd1 e_rd2 e_dbg e_rd1_nb | e_b1 e_b2 e_nb
      vt[0]  = '{1'b0,5'd0,32'h0,4'h0,        1'b0,5'd0,32'h0,4'h0,        1'b0,5'd0, 5'd5,5'd0,5'd5, 32'h0,32'h0,32'h0,32'h0,                         1'b0,1'b0,6'd0};
      vt[1]  = '{1'b1,5'd5,32'h12345678,4'hF, 1'b0,5'd0,32'h0,4'h0,        1'b0,5'd0, 5'd5,5'd5,5'd5, 32'h12345678,32'h12345678,32'h0,32'h0,           1'b0,1'b0,6'd0};
      vt[2]  = '{1'b1,5'd0,32'hFFFFFFFF,4'hF, 1'b0,5'd0,32'h0,4'h0,        1'b0,5'd0, 5'd5,5'd0,5'd5, 32'h12345678,32'h0,32'h12345678,32'h12345678,    1'b0,1'b0,6'd0};
      vt[3]  = '{1'b0,5'd0,32'h0,4'h0,        1'b0,5'd0,32'h0,4'h0,        1'b0,5'd0, 5'd0,5'd5,5'd0, 32'h0,32'h12345678,32'h0,32'h0,                  1'b0,1'b0,6'd0};
      vt[4]  = '{1'b1,5'd3,32'hAAAAAAAA,4'hF, 1'b1,5'd3,32'h55555555,4'h3, 1'b0,5'd0, 5'd3,5'd5,5'd3, 32'hAAAA5555,32'h12345678,32'h0,32'h0,           1'b0,1'b0,6'd0};
      vt[5]  = '{1'b0,5'd0,32'h0,4'h0,        1'b0,5'd0,32'h0,4'h0,        1'b0,5'd0, 5'd3,5'd3,5'd3, 32'hAAAA5555,32'hAAAA5555,32'hAAAA5555,32'hAAAA5555, 1'b0,1'b0,6'd0};
      vt[6]  = '{1'b1,5'd5,32'hDEADBEEF,4'h4, 1'b0,5'd0,32'h0,4'h0,        1'b0,5'd0, 5'd5,5'd5,5'd5, 32'h12AD5678,32'h12AD5678,32'h12345678,32'h12345678, 1'b0,1'b0,6'd0};
      vt[7]  = '{1'b1,5'd3,32'h11223344,4'h9, 1'b1,5'd5,32'hFFFFFFFF,4'h0, 1'b0,5'd0, 5'd5,5'd3,5'd3, 32'h12AD5678,32'h11AA5544,32'hAAAA5555,32'h12AD5678, 1'b0,1'b0,6'd0};
      vt[8]  = '{1'b0,5'd0,32'h0,4'h0,        1'b0,5'd0,32'h0,4'h0,        1'b1,5'd7, 5'd7,5'd3,5'd0, 32'h0,32'h11AA5544,32'h0,32'h0,                  1'b0,1'b0,6'd0};
      vt[9]  = '{1'b0,5'd0,32'h0,4'h0,        1'b0,5'd0,32'h0,4'h0,        1'b0,5'd0, 5'd7,5'd3,5'd7, 32'h0,32'h11AA5544,32'h0,32'h0,                  1'b1,1'b0,6'd1};
      vt[10] = '{1'b1,5'd7,32'h00000077,4'hF, 1'b0,5'd0,32'h0,4'h0,        1'b0,5'd0, 5'd7,5'd7,5'd7, 32'h77,32'h77,32'h0,32'h0,                       1'b0,1'b0,6'd1};
      vt[11] = '{1'b0,5'd0,32'h0,4'h0,        1'b0,5'd0,32'h0,4'h0,        1'b0,5'd0, 5'd7,5'd0,5'd7, 32'h77,32'h0,32'h77,32'h77,                      1'b0,1'b0,6'd0};
      vt[12] = '{1'b0,5'd0,32'h0,4'h0,        1'b1,5'd7,32'h00000099,4'h1, 1'b1,5'd7, 5'd7,5'd7,5'd7, 32'h99,32'h99,32'h77,32'h77,                     1'b0,1'b0,6'd0};
      vt[13] = '{1'b0,5'd0,32'h0,4'h0,        1'b0,5'd0,32'h0,4'h0,        1'b0,5'd0, 5'd7,5'd7,5'd7, 32'h99,32'h99,32'h99,32'h99,                     1'b1,1'b1,6'd1};
      vt[14] = '{1'b1,5'd7,32'h000000FF,4'h0, 1'b0,5'd0,32'h0,4'h0,        1'b1,5'd7, 5'd7,5'd2,5'd7, 32'h99,32'h0,32'h99,32'h99,                      1'b0,1'b0,6'd1};
      vt[15] = '{1'b0,5'd0,32'h0,4'h0,        1'b0,5'd0,32'h0,4'h0,        1'b0,5'd0, 5'd7,5'd0,5'd7, 32'h99,32'h0,32'h99,32'h99,                      1'b1,1'b0,6'd1};
      vt[16] = '{1'b1,5'd7,32'h000000FF,4'h0, 1'b0,5'd0,32'h0,4'h0,        1'b1,5'd0, 5'd4,5'd7,5'd0, 32'h0,32'h99,32'h0,32'h0,                        1'b0,1'b0,6'd1};
      vt[17] = '{1'b0,5'd0,32'h0,4'h0,        1'b0,5'd0,32'h0,4'h0,        1'b0,5'd0, 5'd7,5'd0,5'd7, 32'h99,32'h0,32'h99,32'h99,                      1'b0,1'b0,6'd0};

      rst = 1'b0;
      apply(idle_v());
      repeat (2) @(negedge clk);
      #1;
      check("reset nbusy", 32'(bi.nbusy), 32'h0);
      check("reset rd1", bi.rd1, 32'h0);
      rst = 1'b1;

      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         apply(vt[i]);
         #1;
         check($sformatf("v%0d rd1", i), bi.rd1, vt[i].e_rd1);
         check($sformatf("v%0d rd2", i), bi.rd2, vt[i].e_rd2);
         check($sformatf("v%0d dbg", i), bi.dbg_data, vt[i].e_dbg);
         check($sformatf("v%0d rd1 nobypass", i), bn.rd1, vt[i].e_rd1_nb);
         check($sformatf("v%0d busy1", i), 32'(bi.busy1), 32'(vt[i].e_b1));
         check($sformatf("v%0d busy2", i), 32'(bi.busy2), 32'(vt[i].e_b2));
         check($sformatf("v%0d nbusy", i), 32'(bi.nbusy), 32'(vt[i].e_nb));
      end

      // Issue every register in turn; count climbs by one per edge
      for (int i = 1; i < 32; i++) begin
         @(negedge clk);
         h = idle_v(); h.iss_v = 1'b1; h.iss_a = 5'(i);
         apply(h);
         #1;
         check($sformatf("fill nbusy %0d", i), 32'(bi.nbusy), 32'(i - 1));
      end
      @(negedge clk);
      h = idle_v(); h.iss_v = 1'b1; h.iss_a = 5'd0;
      apply(h);
      #1;
      check("nbusy full", 32'(bi.nbusy), 32'd31);
      @(negedge clk);
      h = idle_v(); h.ra1 = 5'd0; h.ra2 = 5'd31;
      apply(h);
      #1;
      check("nbusy after r0 issue", 32'(bi.nbusy), 32'd31);
      check("busy r0", 32'(bi.busy1), 32'h0);
      check("busy r31", 32'(bi.busy2), 32'h1);

      // Fill r1..r4, re-issue r2, then drop reset between edges
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         h = idle_v(); h.we0 = 1'b1; h.wa0 = 5'(i); h.wd0 = 32'h11111111 * 32'(i); h.wbe0 = 4'hF;
         apply(h);
         #1;
         check($sformatf("drain nbusy %0d", i), 32'(bi.nbusy), 32'(32 - i));
      end
      @(negedge clk);
      h = idle_v(); h.iss_v = 1'b1; h.iss_a = 5'd2;
      apply(h);
      #1;
      check("pre-issue nbusy", 32'(bi.nbusy), 32'd27);
      @(negedge clk);
      h = idle_v(); h.ra1 = 5'd2; h.ra2 = 5'd4; h.dbg = 5'd1;
      apply(h);
      #1;
      check("pre-rst rd1", bi.rd1, 32'h22222222);
      check("pre-rst rd2", bi.rd2, 32'h44444444);
      check("pre-rst dbg", bi.dbg_data, 32'h11111111);
      check("pre-rst nbusy", 32'(bi.nbusy), 32'd28);
      check("pre-rst busy1", 32'(bi.busy1), 32'h1);
      #1;
      rst = 1'b0;
      #1;
      check("rst rd1", bi.rd1, 32'h0);
      check("rst rd2", bi.rd2, 32'h0);
      check("rst dbg", bi.dbg_data, 32'h0);
      check("rst nbusy", 32'(bi.nbusy), 32'h0);
      check("rst busy1", 32'(bi.busy1), 32'h0);
      @(negedge clk);
      h = idle_v(); h.we0 = 1'b1; h.wa0 = 5'd1; h.wd0 = 32'hABCD0123; h.wbe0 = 4'hF;
      h.iss_v = 1'b1; h.iss_a = 5'd9; h.ra1 = 5'd1; h.ra2 = 5'd9; h.dbg = 5'd1;
      apply(h);
      #1;
      check("in-rst bypass rd1", bi.rd1, 32'h0);
      check("in-rst nbusy", 32'(bi.nbusy), 32'h0);
      @(negedge clk);
      rst = 1'b1;
      h = idle_v(); h.we0 = 1'b1; h.wa0 = 5'd6; h.wd0 = 32'h00000066; h.wbe0 = 4'hF;
      h.iss_v = 1'b1; h.iss_a = 5'd9; h.ra1 = 5'd1; h.ra2 = 5'd9; h.dbg = 5'd1;
      apply(h);
      #1;
      check("post-rst rd1", bi.rd1, 32'h0);
      check("post-rst dbg", bi.dbg_data, 32'h0);
      check("post-rst busy2", 32'(bi.busy2), 32'h0);
      check("post-rst nbusy", 32'(bi.nbusy), 32'h0);
      @(negedge clk);
      h = idle_v(); h.ra1 = 5'd9; h.ra2 = 5'd2; h.dbg = 5'd6;
      apply(h);
      #1;
      check("first edge dbg", bi.dbg_data, 32'h66);
      check("first edge busy1", 32'(bi.busy1), 32'h1);
      check("first edge nbusy", 32'(bi.nbusy), 32'h1);
      check("first edge rd2", bi.rd2, 32'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
